dmem_arbiter: RTL and testbench

Two-master arbiter for the shared data port of the dual-port instruction/data memory. Master 0 (core load/store unit) and master 1 (debug/loader) each issue single-beat read/write requests; the arbiter grants one beat per cycle round-robin and supports locked multi-beat sequences (read-modify-write, loader bursts) with a timeout. It returns read data with fixed latency to the master that issued the read. It sits between the core/debug logic and the memory's data-address, write-enable, write-data and data-out pins; the instruction port is not touched.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared data port of the I/D memory, with locked
// multi-beat ownership, a lock timeout, and per-master read-return tracking.
module dmem_arbiter #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 1024,
   parameter int RD_LAT   = 1,
   parameter int MAX_LOCK = 15,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             m0_req,
   input  logic             m0_we,
   input  logic             m0_lock,
   input  logic [AW-1:0]    m0_addr,
   input  logic [WIDTH-1:0] m0_wdata,
   output logic             m0_ready,
   output logic             m0_rvalid,
   output logic [WIDTH-1:0] m0_rdata,
   input  logic             m1_req,
   input  logic             m1_we,
   input  logic             m1_lock,
   input  logic [AW-1:0]    m1_addr,
   input  logic [WIDTH-1:0] m1_wdata,
   output logic             m1_ready,
   output logic             m1_rvalid,
   output logic [WIDTH-1:0] m1_rdata,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             lock_timeout
);

   // state | meaning
   // IDLE  | no owner; round-robin between requesters, rr_ptr breaks ties
   // OWN0  | master 0 holds a lock; master 1 is stalled
   // OWN1  | master 1 holds a lock; master 0 is stalled

   localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
   localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t            state;
   logic              rr_ptr;
   logic [LCW-1:0]    lock_cnt;
   logic [RD_LAT-1:0] rd_vld;
   logic [RD_LAT-1:0] rd_id;

   logic grant0, grant1, grant, gid, g_we, g_lock, owner;

   // Grant depends only on requests, state and rr_ptr, never on ready.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      case (state)
         IDLE: begin
            grant0 = m0_req & (~m1_req | ~rr_ptr);
            grant1 = m1_req & (~m0_req | rr_ptr);
         end
         OWN0:    grant0 = m0_req;
         OWN1:    grant1 = m1_req;
         default: ;
      endcase
   end

   assign grant  = grant0 | grant1;
   assign gid    = grant1;
   assign g_we   = grant1 ? m1_we   : m0_we;
   assign g_lock = grant1 ? m1_lock : m0_lock;
   assign owner  = (state == OWN1);

   assign m0_ready  = grant0;
   assign m1_ready  = grant1;
   assign mem_we    = grant & g_we;
   assign mem_addr  = grant1 ? m1_addr  : m0_addr;
   assign mem_wdata = grant1 ? m1_wdata : m0_wdata;

   assign m0_rvalid = rd_vld[RD_LAT-1] & ~rd_id[RD_LAT-1];
   assign m1_rvalid = rd_vld[RD_LAT-1] &  rd_id[RD_LAT-1];
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         rr_ptr       <= 1'b0;
         lock_cnt     <= '0;
         lock_timeout <= 1'b0;
         rd_vld       <= '0;
         rd_id        <= '0;
      end else begin
         lock_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  if (g_lock) begin
                     state    <= gid ? OWN1 : OWN0;
                     lock_cnt <= '0;
                  end else begin
                     rr_ptr <= ~gid;
                  end
               end
            end
            OWN0, OWN1: begin
               // A releasing beat wins over the timeout, so no pulse then.
               if (grant && !g_lock) begin
                  state    <= IDLE;
                  rr_ptr   <= ~owner;
                  lock_cnt <= '0;
               end else if (lock_cnt == LOCK_LAST) begin
                  state        <= IDLE;
                  rr_ptr       <= ~owner;
                  lock_cnt     <= '0;
                  lock_timeout <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt + LCW'(1);
               end
            end
            default: state <= IDLE;
         endcase

         rd_vld[0] <= grant & ~g_we;
         rd_id[0]  <= gid;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_vld[i] <= rd_vld[i-1];
            rd_id[i]  <= rd_id[i-1];
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=3 share the same master stimulus, each with its own memory model.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [9:0]  m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;

   logic        m0_ready1, m0_rvalid1, m1_ready1, m1_rvalid1, mem_we1, lock_timeout1;
   logic [15:0] m0_rdata1, m1_rdata1, mem_wdata1, mem_rdata1;
   logic [9:0]  mem_addr1;

   logic        m0_ready3, m0_rvalid3, m1_ready3, m1_rvalid3, mem_we3, lock_timeout3;
   logic [15:0] m0_rdata3, m1_rdata3, mem_wdata3, mem_rdata3;
   logic [9:0]  mem_addr3;

   logic [15:0] mem1 [1024];
   logic [15:0] mem3 [1024];
   logic [15:0] rp3 [3];

   int n_chk  = 0;
   int n_pass = 0;

   dmem_arbiter #(.WIDTH(16), .DEPTH(1024), .RD_LAT(1), .MAX_LOCK(15)) u_dut1 (
      .clock(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ready(m0_ready1), .m0_rvalid(m0_rvalid1), .m0_rdata(m0_rdata1),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ready(m1_ready1), .m1_rvalid(m1_rvalid1), .m1_rdata(m1_rdata1),
      .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
      .lock_timeout(lock_timeout1)
   );

   dmem_arbiter #(.WIDTH(16), .DEPTH(1024), .RD_LAT(3), .MAX_LOCK(15)) u_dut3 (
      .clock(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ready(m0_ready3), .m0_rvalid(m0_rvalid3), .m0_rdata(m0_rdata3),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ready(m1_ready3), .m1_rvalid(m1_rvalid3), .m1_rdata(m1_rdata3),
      .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
      .lock_timeout(lock_timeout3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: word i holds 0x1000+i, except word 5 holds 0xBEEF.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem1[i] <= 16'h1000 + 16'(i);
         mem1[5]    <= 16'hBEEF;
         mem_rdata1 <= '0;
      end else begin
         if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
         mem_rdata1 <= mem1[mem_addr1];
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem3[i] <= 16'h1000 + 16'(i);
         mem3[5] <= 16'hBEEF;
         for (int i = 0; i < 3; i++) rp3[i] <= '0;
      end else begin
         if (mem_we3) mem3[mem_addr3] <= mem_wdata3;
         rp3[0] <= mem3[mem_addr3];
         rp3[1] <= rp3[0];
         rp3[2] <= rp3[1];
      end
   end
   assign mem_rdata3 = rp3[2];

   task automatic drive(input logic r0, input logic w0, input logic l0, input logic [9:0] a0,
                        input logic [15:0] d0, input logic r1, input logic w1, input logic l1,
                        input logic [9:0] a1, input logic [15:0] d1);
      m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 10'd0, 16'h0, 0, 0, 0, 10'd0, 16'h0);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      n_chk++; if (m0_rvalid1 !== 1'b0) $display("FAIL reset_m0_rvalid got %0b exp 0", m0_rvalid1); else n_pass++;
      n_chk++; if (m1_rvalid1 !== 1'b0) $display("FAIL reset_m1_rvalid got %0b exp 0", m1_rvalid1); else n_pass++;
      n_chk++; if (mem_we1 !== 1'b0) $display("FAIL reset_mem_we got %0b exp 0", mem_we1); else n_pass++;
      n_chk++; if (lock_timeout1 !== 1'b0) $display("FAIL reset_lock_timeout got %0b exp 0", lock_timeout1); else n_pass++;
      n_chk++; if (m0_rvalid3 !== 1'b0 || m1_rvalid3 !== 1'b0) $display("FAIL reset_rvalid3 got %0b%0b exp 00", m0_rvalid3, m1_rvalid3); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      do_reset();
      next_cycle();
      drive(1, 0, 0, 10'd5, 16'h0, 0, 0, 0, 10'd0, 16'h0);
      #1;
      n_chk++; if (m0_ready1 !== 1'b1) $display("FAIL rd_m0_ready got %0b exp 1", m0_ready1); else n_pass++;
      n_chk++; if (mem_addr1 !== 10'd5) $display("FAIL rd_mem_addr got %0d exp 5", mem_addr1); else n_pass++;
      n_chk++; if (mem_we1 !== 1'b0) $display("FAIL rd_mem_we got %0b exp 0", mem_we1); else n_pass++;
      next_cycle();
      idle();
      #1;
      n_chk++; if (m0_rvalid1 !== 1'b1) $display("FAIL rd_m0_rvalid got %0b exp 1", m0_rvalid1); else n_pass++;
      n_chk++; if (m0_rdata1 !== 16'hBEEF) $display("FAIL rd_m0_rdata got %h exp beef", m0_rdata1); else n_pass++;
      n_chk++; if (m1_rvalid1 !== 1'b0) $display("FAIL rd_m1_rvalid got %0b exp 0", m1_rvalid1); else n_pass++;
      next_cycle();
      #1;
      n_chk++; if (m0_rvalid1 !== 1'b0) $display("FAIL rd_m0_rvalid_once got %0b exp 0", m0_rvalid1); else n_pass++;
   endtask

   task automatic test_round_robin();
      int pa;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         drive(1, 0, 0, 10'(20 + i), 16'h0, 1, 0, 0, 10'(40 + i), 16'h0);
         #1;
         n_chk++; if (m0_ready1 !== ((i % 2) == 0)) $display("FAIL rr_m0_ready[%0d] got %0b exp %0b", i, m0_ready1, (i % 2) == 0); else n_pass++;
         n_chk++; if (m1_ready1 !== ((i % 2) == 1)) $display("FAIL rr_m1_ready[%0d] got %0b exp %0b", i, m1_ready1, (i % 2) == 1); else n_pass++;
         n_chk++; if (mem_addr1 !== (((i % 2) == 0) ? 10'(20 + i) : 10'(40 + i))) $display("FAIL rr_mem_addr[%0d] got %0d", i, mem_addr1); else n_pass++;
         if (i > 0) begin
            pa = ((i - 1) % 2 == 0) ? 20 + i - 1 : 40 + i - 1;
            n_chk++; if (m0_rvalid1 !== ((i - 1) % 2 == 0) || m1_rvalid1 !== ((i - 1) % 2 == 1))
               $display("FAIL rr_rvalid[%0d] got %0b%0b", i, m0_rvalid1, m1_rvalid1); else n_pass++;
            n_chk++; if (m0_rdata1 !== 16'h1000 + 16'(pa)) $display("FAIL rr_rdata[%0d] got %h exp %h", i, m0_rdata1, 16'h1000 + 16'(pa)); else n_pass++;
         end
      end
      next_cycle();
      idle();
      #1;
      n_chk++; if (m1_rvalid1 !== 1'b1 || m0_rvalid1 !== 1'b0) $display("FAIL rr_last_rvalid got %0b%0b exp 01", m0_rvalid1, m1_rvalid1); else n_pass++;
      n_chk++; if (m1_rdata1 !== 16'h102D) $display("FAIL rr_last_rdata got %h exp 102d", m1_rdata1); else n_pass++;
   endtask

   task automatic test_lock_rmw();
      do_reset();
      next_cycle();
      drive(1, 0, 0, 10'd3, 16'h0, 0, 0, 0, 10'd0, 16'h0);
      next_cycle();
      drive(1, 0, 0, 10'd7, 16'h0, 1, 1, 1, 10'd10, 16'h1234);
      #1;
      n_chk++; if (m0_ready1 !== 1'b0 || m1_ready1 !== 1'b1) $display("FAIL lk_a_ready got %0b%0b exp 01", m0_ready1, m1_ready1); else n_pass++;
      n_chk++; if (mem_we1 !== 1'b1 || mem_addr1 !== 10'd10 || mem_wdata1 !== 16'h1234)
         $display("FAIL lk_a_write got we=%0b addr=%0d data=%h", mem_we1, mem_addr1, mem_wdata1); else n_pass++;
      n_chk++; if (m0_rvalid1 !== 1'b1 || m0_rdata1 !== 16'h1003) $display("FAIL lk_p_read got %0b %h exp 1 1003", m0_rvalid1, m0_rdata1); else n_pass++;
      next_cycle();
      drive(1, 0, 0, 10'd7, 16'h0, 1, 0, 0, 10'd10, 16'h0);
      #1;
      n_chk++; if (m0_ready1 !== 1'b0 || m1_ready1 !== 1'b1) $display("FAIL lk_b_ready got %0b%0b exp 01", m0_ready1, m1_ready1); else n_pass++;
      n_chk++; if (mem_we1 !== 1'b0 || mem_addr1 !== 10'd10) $display("FAIL lk_b_mem got we=%0b addr=%0d", mem_we1, mem_addr1); else n_pass++;
      next_cycle();
      drive(1, 0, 0, 10'd7, 16'h0, 0, 0, 0, 10'd0, 16'h0);
      #1;
      n_chk++; if (m0_ready1 !== 1'b1 || mem_addr1 !== 10'd7) $display("FAIL lk_c_m0 got ready=%0b addr=%0d", m0_ready1, mem_addr1); else n_pass++;
      n_chk++; if (m1_rvalid1 !== 1'b1 || m1_rdata1 !== 16'h1234) $display("FAIL lk_c_m1_read got %0b %h exp 1 1234", m1_rvalid1, m1_rdata1); else n_pass++;
      next_cycle();
      idle();
      #1;
      n_chk++; if (m0_rvalid1 !== 1'b1 || m1_rvalid1 !== 1'b0 || m0_rdata1 !== 16'h1007)
         $display("FAIL lk_d_m0_read got %0b%0b %h", m0_rvalid1, m1_rvalid1, m0_rdata1); else n_pass++;
   endtask

   task automatic test_lock_timeout();
      do_reset();
      next_cycle();
      drive(1, 0, 1, 10'd1, 16'h0, 0, 0, 0, 10'd0, 16'h0);
      #1;
      n_chk++; if (m0_ready1 !== 1'b1) $display("FAIL to_lock_ready got %0b exp 1", m0_ready1); else n_pass++;
      for (int k = 1; k <= 15; k++) begin
         next_cycle();
         drive(0, 0, 0, 10'd0, 16'h0, 1, 0, 0, 10'd2, 16'h0);
         #1;
         n_chk++; if (m1_ready1 !== 1'b0 || lock_timeout1 !== 1'b0)
            $display("FAIL to_hold[%0d] got ready=%0b to=%0b exp 0 0", k, m1_ready1, lock_timeout1); else n_pass++;
      end
      next_cycle();
      drive(1, 0, 0, 10'd0, 16'h0, 1, 0, 0, 10'd2, 16'h0);
      #1;
      n_chk++; if (lock_timeout1 !== 1'b1) $display("FAIL to_pulse got %0b exp 1", lock_timeout1); else n_pass++;
      n_chk++; if (m1_ready1 !== 1'b1 || m0_ready1 !== 1'b0) $display("FAIL to_rr_ptr got %0b%0b exp 01", m0_ready1, m1_ready1); else n_pass++;
      next_cycle();
      idle();
      #1;
      n_chk++; if (lock_timeout1 !== 1'b0) $display("FAIL to_pulse_once got %0b exp 0", lock_timeout1); else n_pass++;
   endtask

   task automatic test_release_at_limit();
      do_reset();
      next_cycle();
      drive(1, 0, 1, 10'd1, 16'h0, 0, 0, 0, 10'd0, 16'h0);
      for (int k = 1; k <= 14; k++) begin
         next_cycle();
         idle();
      end
      next_cycle();
      drive(1, 1, 0, 10'd4, 16'h5A5A, 1, 0, 0, 10'd2, 16'h0);
      #1;
      n_chk++; if (m0_ready1 !== 1'b1 || m1_ready1 !== 1'b0) $display("FAIL rel_last_ready got %0b%0b exp 10", m0_ready1, m1_ready1); else n_pass++;
      next_cycle();
      drive(1, 0, 0, 10'd0, 16'h0, 1, 0, 0, 10'd2, 16'h0);
      #1;
      n_chk++; if (lock_timeout1 !== 1'b0) $display("FAIL rel_no_pulse got %0b exp 0", lock_timeout1); else n_pass++;
      n_chk++; if (m1_ready1 !== 1'b1 || m0_ready1 !== 1'b0) $display("FAIL rel_rr_ptr got %0b%0b exp 01", m0_ready1, m1_ready1); else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      next_cycle();
      drive(1, 0, 0, 10'd5, 16'h0, 0, 0, 0, 10'd0, 16'h0);
      #1;
      n_chk++; if (m0_ready3 !== 1'b1) $display("FAIL mr_ready got %0b exp 1", m0_ready3); else n_pass++;
      next_cycle();
      idle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      #1;
      n_chk++; if (m0_rvalid1 !== 1'b0 || mem_we1 !== 1'b0 || lock_timeout1 !== 1'b0)
         $display("FAIL mr_outputs got rv=%0b we=%0b to=%0b exp 0", m0_rvalid1, mem_we1, lock_timeout1); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_chk++; if (m0_rvalid3 !== 1'b0 || m1_rvalid3 !== 1'b0)
            $display("FAIL mr_dropped[%0d] got %0b%0b exp 00", k, m0_rvalid3, m1_rvalid3); else n_pass++;
         next_cycle();
         #1;
      end
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      next_cycle();
      drive(1, 0, 1, 10'd1, 16'h0, 0, 0, 0, 10'd0, 16'h0);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         idle();
      end
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      for (int k = 0; k < 16; k++) begin
         drive(0, 0, 0, 10'd0, 16'h0, 1, 0, 0, 10'd9, 16'h0);
         #1;
         n_chk++; if (m1_ready1 !== 1'b1 || lock_timeout1 !== 1'b0)
            $display("FAIL ml_released[%0d] got ready=%0b to=%0b exp 1 0", k, m1_ready1, lock_timeout1); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_back_to_back_lat3();
      do_reset();
      next_cycle();
      drive(1, 0, 0, 10'd50, 16'h0, 0, 0, 0, 10'd0, 16'h0);
      #1;
      n_chk++; if (m0_ready3 !== 1'b1) $display("FAIL l3_c0_ready got %0b exp 1", m0_ready3); else n_pass++;
      next_cycle();
      drive(0, 0, 0, 10'd0, 16'h0, 1, 0, 0, 10'd51, 16'h0);
      #1;
      n_chk++; if (m1_ready3 !== 1'b1 || m0_rvalid3 !== 1'b0 || m1_rvalid3 !== 1'b0)
         $display("FAIL l3_c1 got ready=%0b rv=%0b%0b", m1_ready3, m0_rvalid3, m1_rvalid3); else n_pass++;
      next_cycle();
      drive(1, 1, 0, 10'd52, 16'hCAFE, 0, 0, 0, 10'd0, 16'h0);
      #1;
      n_chk++; if (mem_we3 !== 1'b1 || m0_rvalid3 !== 1'b0 || m1_rvalid3 !== 1'b0)
         $display("FAIL l3_c2 got we=%0b rv=%0b%0b", mem_we3, m0_rvalid3, m1_rvalid3); else n_pass++;
      next_cycle();
      idle();
      #1;
      n_chk++; if (m0_rvalid3 !== 1'b1 || m1_rvalid3 !== 1'b0 || m0_rdata3 !== 16'h1032)
         $display("FAIL l3_c3 got rv=%0b%0b data=%h exp 10 1032", m0_rvalid3, m1_rvalid3, m0_rdata3); else n_pass++;
      next_cycle();
      #1;
      n_chk++; if (m0_rvalid3 !== 1'b0 || m1_rvalid3 !== 1'b1 || m1_rdata3 !== 16'h1033)
         $display("FAIL l3_c4 got rv=%0b%0b data=%h exp 01 1033", m0_rvalid3, m1_rvalid3, m1_rdata3); else n_pass++;
      next_cycle();
      #1;
      n_chk++; if (m0_rvalid3 !== 1'b0 || m1_rvalid3 !== 1'b0) $display("FAIL l3_c5_write got rv=%0b%0b exp 00", m0_rvalid3, m1_rvalid3); else n_pass++;
      next_cycle();
      #1;
      n_chk++; if (m0_rvalid3 !== 1'b0 || m1_rvalid3 !== 1'b0) $display("FAIL l3_c6 got rv=%0b%0b exp 00", m0_rvalid3, m1_rvalid3); else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_single_read();
      test_round_robin();
      test_lock_rmw();
      test_lock_timeout();
      test_release_at_limit();
      test_reset_mid_read();
      test_reset_mid_lock();
      test_back_to_back_lat3();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
